// File: rtl/uart_block_sender.sv
// Serialises a DW-bit block into NBYTES bytes, MSB byte first, handshaking each byte
// with a UART transmitter through a level request (uart_tx_en) and completion flag (send_ok).
module uart_block_sender #(
    parameter int unsigned NBYTES = 16,
    parameter int unsigned DW     = 128
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic [DW-1:0] blk_data,
    input  logic          blk_valid,
    output logic          blk_ready,
    output logic [7:0]    uart_data,
    output logic          uart_tx_en,
    input  logic          send_ok,
    output logic          busy,
    output logic          done,
    output logic [3:0]    byte_idx
);

    typedef enum logic [1:0] {StIdle, StSend, StGap, StDone} state_e;

    localparam logic [3:0] LastIdx = 4'(NBYTES - 1);

    state_e        state_q, state_d;
    logic [DW-1:0] shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          tx_en_q, tx_en_d;
    logic [3:0]    idx_q, idx_d;
    logic          done_q, done_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= StIdle;
            shift_q <= '0;
            data_q  <= 8'h00;
            tx_en_q <= 1'b0;
            idx_q   <= 4'd0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            tx_en_q <= tx_en_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        data_d  = data_q;
        tx_en_d = tx_en_q;
        idx_d   = idx_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                tx_en_d = 1'b0;
                if (blk_valid && ready_q) begin
                    shift_d = blk_data;
                    idx_d   = 4'd0;
                    data_d  = blk_data[DW-1 -: 8];
                    tx_en_d = 1'b1;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (send_ok) begin
                    tx_en_d = 1'b0;
                    state_d = StGap;
                end
            end
            StGap: begin
                // Wait for send_ok to fall so the transmitter sees a fresh request edge.
                if (!send_ok) begin
                    if (idx_q == LastIdx) begin
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        shift_d = shift_q << 8;
                        idx_d   = idx_q + 4'd1;
                        data_d  = shift_d[DW-1 -: 8];
                        tx_en_d = 1'b1;
                        state_d = StSend;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Registered outputs track the state being entered.
        ready_d = (state_d == StIdle);
        busy_d  = (state_d != StIdle);
    end

    assign blk_ready  = ready_q;
    assign uart_data  = data_q;
    assign uart_tx_en = tx_en_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign byte_idx   = idx_q;

endmodule

// File: tb/tb_uart_block_sender.sv
// Directed bench: a 16-byte sender and a 1-byte sender, each driven by a behavioural
// UART transmitter model with programmable completion latency and send_ok hold time.
module tb_uart_block_sender;

    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic         sys_rst_n;
    logic [127:0] blk_data_a;
    logic [7:0]   blk_data_b;
    logic         valid_a, valid_b;
    logic         ready_a, ready_b;
    logic [7:0]   udata_a, udata_b;
    logic         en_a, en_b;
    logic         busy_a, busy_b;
    logic         done_a, done_b;
    logic [3:0]   idx_a, idx_b;
    logic         ok_q [2];

    uart_block_sender #(.NBYTES(16), .DW(128)) u_dut_a (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .blk_data   (blk_data_a),
        .blk_valid  (valid_a),
        .blk_ready  (ready_a),
        .uart_data  (udata_a),
        .uart_tx_en (en_a),
        .send_ok    (ok_q[0]),
        .busy       (busy_a),
        .done       (done_a),
        .byte_idx   (idx_a)
    );

    uart_block_sender #(.NBYTES(1), .DW(8)) u_dut_b (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .blk_data   (blk_data_b),
        .blk_valid  (valid_b),
        .blk_ready  (ready_b),
        .uart_data  (udata_b),
        .uart_tx_en (en_b),
        .send_ok    (ok_q[1]),
        .busy       (busy_b),
        .done       (done_b),
        .byte_idx   (idx_b)
    );

    logic [1:0] en_w, busy_w, done_w, ready_w;
    logic [7:0] data_w [2];
    logic [3:0] idx_w [2];
    assign en_w      = {en_b, en_a};
    assign busy_w    = {busy_b, busy_a};
    assign done_w    = {done_b, done_a};
    assign ready_w   = {ready_b, ready_a};
    assign data_w[0] = udata_a;
    assign data_w[1] = udata_b;
    assign idx_w[0]  = idx_a;
    assign idx_w[1]  = idx_b;

    // Transmitter model: send_ok rises lat_cfg cycles into a request, then falls
    // hold_cfg+1 cycles after the request drops. Each completed byte is logged.
    int         lat_cfg  = 20;
    int         hold_cfg = 0;
    int         cnt [2];
    int         hcnt [2];
    logic [7:0] log0 [$];
    logic [7:0] log1 [$];

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int c = 0; c < 2; c++) begin
                ok_q[c] <= 1'b0;
                cnt[c]  <= 0;
                hcnt[c] <= 0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (!ok_q[c]) begin
                    if (en_w[c]) begin
                        if (cnt[c] >= lat_cfg - 1) begin
                            ok_q[c] <= 1'b1;
                            cnt[c]  <= 0;
                            hcnt[c] <= 0;
                            if (c == 0) log0.push_back(data_w[c]);
                            else        log1.push_back(data_w[c]);
                        end else begin
                            cnt[c] <= cnt[c] + 1;
                        end
                    end else begin
                        cnt[c] <= 0;
                    end
                end else if (!en_w[c]) begin
                    if (hcnt[c] >= hold_cfg) ok_q[c] <= 1'b0;
                    else                     hcnt[c] <= hcnt[c] + 1;
                end
            end
        end
    end

    // Protocol monitor: request rising under send_ok, data changing mid-request,
    // and cycles spent with send_ok high and the request low.
    int         rise_viol [2] = '{0, 0};
    int         unstable [2]  = '{0, 0};
    int         okhi_enlo [2] = '{0, 0};
    logic       prev_en [2]   = '{1'b0, 1'b0};
    logic [7:0] first_data [2];

    always @(negedge sys_clk) begin
        for (int c = 0; c < 2; c++) begin
            if (en_w[c] && !prev_en[c] && ok_q[c]) rise_viol[c] <= rise_viol[c] + 1;
            if (en_w[c] && prev_en[c] && data_w[c] != first_data[c])
                unstable[c] <= unstable[c] + 1;
            if (en_w[c] && !prev_en[c]) first_data[c] <= data_w[c];
            if (ok_q[c] && !en_w[c]) okhi_enlo[c] <= okhi_enlo[c] + 1;
            prev_en[c] <= en_w[c];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input int c, input string tag);
        for (int i = 0; i < 100; i++) begin
            if (ready_w[c]) break;
            @(negedge sys_clk);
        end
        check({tag, "_ready"}, ready_w[c], 1);
    endtask

    task automatic wait_done(input int c, input string tag);
        bit seen = 0;
        int busy_low = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge sys_clk);
            if (done_w[c]) begin
                seen = 1;
                break;
            end
            if (!busy_w[c]) busy_low++;
        end
        check({tag, "_done_seen"}, seen, 1);
        check({tag, "_busy_held"}, busy_low, 0);
    endtask

    function automatic logic [127:0] pack_log(input int c, input int first, input int n);
        logic [127:0] v = '0;
        for (int i = first; i < first + n; i++) v = (v << 8) | (c == 0 ? log0[i] : log1[i]);
        return v;
    endfunction

    task automatic run_block(input int c, input logic [127:0] data, input int nb,
                             input string tag);
        int           rv0, us0, n;
        logic [127:0] first;
        wait_ready(c, tag);
        if (c == 0) log0.delete();
        else        log1.delete();
        rv0 = rise_viol[c];
        us0 = unstable[c];
        if (c == 0) begin
            blk_data_a = data;
            valid_a    = 1'b1;
        end else begin
            blk_data_b = data[7:0];
            valid_b    = 1'b1;
        end
        @(negedge sys_clk);
        valid_a = 1'b0;
        valid_b = 1'b0;
        first = data >> (8 * (nb - 1));
        check({tag, "_busy_start"}, busy_w[c], 1);
        check({tag, "_idx_start"}, idx_w[c], 0);
        check({tag, "_data_start"}, data_w[c], first[7:0]);
        wait_done(c, tag);
        @(negedge sys_clk);
        check({tag, "_done_pulse"}, done_w[c], 0);
        check({tag, "_busy_end"}, busy_w[c], 0);
        check({tag, "_ready_end"}, ready_w[c], 1);
        n = (c == 0) ? log0.size() : log1.size();
        check({tag, "_nbytes"}, n, nb);
        if (n == nb) check({tag, "_bytes"}, pack_log(c, 0, nb), data);
        check({tag, "_rise_viol"}, rise_viol[c] - rv0, 0);
        check({tag, "_unstable"}, unstable[c] - us0, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int o0, rdy_hi, n;
        sys_rst_n  = 1'b0;
        valid_a    = 1'b0;
        valid_b    = 1'b0;
        blk_data_a = '0;
        blk_data_b = '0;
        #1;
        check("rst_ready", ready_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_en", en_a, 0);
        check("rst_data", udata_a, 0);
        check("rst_done", done_a, 0);
        check("rst_idx", idx_a, 0);
        check("rst_b_ready", ready_b, 0);
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        check("ready_after_rst", ready_a, 1);
        check("ready_after_rst_b", ready_b, 1);

        // Ordered bytes through a slow transmitter.
        run_block(0, 128'h000102030405060708090A0B0C0D0E0F, 16, "seq");

        // send_ok lingers 5 cycles after each request drops.
        lat_cfg  = 3;
        hold_cfg = 5;
        o0 = okhi_enlo[0];
        run_block(0, 128'h0123456789ABCDEFFEDCBA9876543210, 16, "hold");
        check("hold_okhi_cycles", okhi_enlo[0] - o0, 16 * 6);
        hold_cfg = 0;

        // blk_valid held across two blocks; B must wait until A completes.
        lat_cfg = 4;
        wait_ready(0, "b2b");
        log0.delete();
        blk_data_a = 128'h101112131415161718191A1B1C1D1E1F;
        valid_a    = 1'b1;
        @(negedge sys_clk);
        check("b2b_a_busy", busy_a, 1);
        check("b2b_a_data", udata_a, 8'h10);
        blk_data_a = 128'h202122232425262728292A2B2C2D2E2F;
        rdy_hi = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge sys_clk);
            if (done_a) break;
            if (ready_a) rdy_hi++;
        end
        check("b2b_a_done", done_a, 1);
        check("b2b_ready_low_in_a", rdy_hi, 0);
        @(negedge sys_clk);
        check("b2b_idle_ready", ready_a, 1);
        check("b2b_idle_busy", busy_a, 0);
        @(negedge sys_clk);
        valid_a = 1'b0;
        check("b2b_b_busy", busy_a, 1);
        check("b2b_b_idx", idx_a, 0);
        check("b2b_b_data", udata_a, 8'h20);
        wait_done(0, "b2b_b");
        @(negedge sys_clk);
        n = log0.size();
        check("b2b_nbytes", n, 32);
        if (n == 32) begin
            check("b2b_bytes_a", pack_log(0, 0, 16), 128'h101112131415161718191A1B1C1D1E1F);
            check("b2b_bytes_b", pack_log(0, 16, 16), 128'h202122232425262728292A2B2C2D2E2F);
        end

        // Reset asserted while byte 7 is being requested.
        lat_cfg = 6;
        wait_ready(0, "mid");
        blk_data_a = 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF;
        valid_a    = 1'b1;
        @(negedge sys_clk);
        valid_a = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (idx_a == 4'd7 && en_a) break;
            @(negedge sys_clk);
        end
        check("mid_reach_byte7", {idx_a, en_a}, {4'd7, 1'b1});
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("mid_rst_en", en_a, 0);
        check("mid_rst_busy", busy_a, 0);
        check("mid_rst_idx", idx_a, 0);
        check("mid_rst_data", udata_a, 0);
        check("mid_rst_ready", ready_a, 0);
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        check("mid_ready_after_rst", ready_a, 1);
        check("mid_busy_after_rst", busy_a, 0);
        run_block(0, {16{8'hFF}}, 16, "after_rst");

        // Single-byte configuration.
        lat_cfg = 20;
        run_block(1, 128'hA5, 1, "nb1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
